// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, control bundle layout and the control decoder.
package decode_pkg;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_RTYPE = 5'b11011;

    localparam logic [15:0] INSTR_NOP  = 16'h0800;
    localparam logic [15:0] INSTR_HALT = 16'h0000;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_XOR, ALU_ANDN, ALU_PASSB} alu_op_e;
    typedef enum logic [1:0] {SRC_RD2, SRC_IMM5S, SRC_IMM5Z, SRC_IMM8S} alu_src_e;
    // Destination field select: [7:5], [10:8], [4:2], link register NREGS-1.
    typedef enum logic [1:0] {DEST_I, DEST_RS, DEST_R, DEST_LINK} reg_dest_e;

    typedef struct packed {
        alu_op_e   alu_op;
        alu_src_e  alu_src;
        reg_dest_e reg_dest;
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      branch;
        logic      jump;
        logic      halt;
        logic      use_rs;
        logic      use_rt;
    } ctrl_t;

    localparam int CTRL_W            = $bits(ctrl_t);
    localparam int CTRL_USE_RT_BIT   = 0;
    localparam int CTRL_USE_RS_BIT   = 1;
    localparam int CTRL_HALT_BIT     = 2;
    localparam int CTRL_REGWRITE_BIT = 7;
    localparam int CTRL_ALU_OP_LSB   = 12;

    function automatic ctrl_t decode_ctrl(input logic [4:0] op, input logic [1:0] func);
        ctrl_t c;
        c = '0;
        case (op)
            OP_HALT: c.halt = 1'b1;
            OP_ADDI, OP_SUBI, OP_XORI: begin
                c.alu_op    = (op == OP_ADDI) ? ALU_ADD : (op == OP_SUBI) ? ALU_SUB : ALU_XOR;
                c.alu_src   = (op == OP_XORI) ? SRC_IMM5Z : SRC_IMM5S;
                c.reg_dest  = DEST_I;
                c.reg_write = 1'b1;
                c.use_rs    = 1'b1;
            end
            OP_LBI: begin
                c.alu_op    = ALU_PASSB;
                c.alu_src   = SRC_IMM8S;
                c.reg_dest  = DEST_RS;
                c.reg_write = 1'b1;
            end
            OP_RTYPE: begin
                c.alu_op    = alu_op_e'({1'b0, func});
                c.reg_dest  = DEST_R;
                c.reg_write = 1'b1;
                c.use_rs    = 1'b1;
                c.use_rt    = 1'b1;
            end
            OP_ST: begin
                c.alu_src   = SRC_IMM5S;
                c.mem_write = 1'b1;
                c.use_rs    = 1'b1;
                c.use_rt    = 1'b1;
            end
            OP_LD: begin
                c.alu_src   = SRC_IMM5S;
                c.reg_dest  = DEST_I;
                c.reg_write = 1'b1;
                c.mem_read  = 1'b1;
                c.use_rs    = 1'b1;
            end
            OP_BEQZ: begin
                c.branch = 1'b1;
                c.use_rs = 1'b1;
            end
            OP_J:   c.jump = 1'b1;
            OP_JAL: begin
                c.jump      = 1'b1;
                c.reg_dest  = DEST_LINK;
                c.reg_write = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register pending-write counters and RAW / in-flight-limit stall detection.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter int NREGS        = 8,
    parameter int MAX_INFLIGHT = 4,
    localparam int RW          = $clog2(NREGS),
    localparam int CW          = $clog2(MAX_INFLIGHT + 1)
)(
    input  logic          clk,
    input  logic          srst,
    input  logic          i_inc_en,
    input  logic [RW-1:0] i_inc_reg,
    input  logic          i_dec_en,
    input  logic [RW-1:0] i_dec_reg,
    input  logic          i_kill_en,
    input  logic [RW-1:0] i_kill_reg,
    input  logic          i_src1_use,
    input  logic [RW-1:0] i_src1,
    input  logic          i_src2_use,
    input  logic [RW-1:0] i_src2,
    input  logic          i_writes,
    output logic          o_stall
);

    localparam int SW = CW + RW;

    logic [CW-1:0] r_pend      [NREGS];
    logic [CW-1:0] w_pend_next [NREGS];
    logic [SW-1:0] w_inflight;
    logic [CW-1:0] w_p1, w_p2;
    logic          w_blk1, w_blk2, w_full;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_pend
            logic [CW:0] w_up, w_down;
            // A writeback to an idle register is an architectural write only.
            assign w_up   = {1'b0, r_pend[gi]} + (CW+1)'(i_inc_en && i_inc_reg == RW'(gi));
            assign w_down = (CW+1)'(i_dec_en && i_dec_reg == RW'(gi) && r_pend[gi] != '0)
                          + (CW+1)'(i_kill_en && i_kill_reg == RW'(gi));
            assign w_pend_next[gi] = (w_up > w_down) ? CW'(w_up - w_down) : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < NREGS; i++) r_pend[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) r_pend[i] <= w_pend_next[i];
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < NREGS; i++) w_inflight = w_inflight + SW'(r_pend[i]);
    end

    // A source whose last pending write lands this cycle is served by the bypass.
    assign w_p1   = r_pend[i_src1];
    assign w_p2   = r_pend[i_src2];
    assign w_blk1 = i_src1_use && (w_p1 != '0) && !(i_dec_en && i_dec_reg == i_src1 && w_p1 == CW'(1));
    assign w_blk2 = i_src2_use && (w_p2 != '0) && !(i_dec_en && i_dec_reg == i_src2 && w_p2 == CW'(1));
    assign w_full = i_writes && (w_inflight >= SW'(MAX_INFLIGHT));
    assign o_stall = w_blk1 || w_blk2 || w_full;

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: register read with writeback bypass, scoreboard hazard
// stall, flush drop window and a valid/ready ID/EX register.
module decode_issue
    import decode_pkg::*;
#(
    parameter int DW           = 16,
    parameter int NREGS        = 8,
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 3,
    localparam int RW          = $clog2(NREGS)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    input  logic              if_align_err,
    output logic              id_ready,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [RW-1:0]     wb_reg,
    input  logic [DW-1:0]     wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DW-1:0]     ex_a,
    output logic [DW-1:0]     ex_b,
    output logic [DW-1:0]     ex_rd2,
    output logic [DW-1:0]     ex_imm8,
    output logic [DW-1:0]     ex_imm11,
    output logic [RW-1:0]     ex_wreg,
    output logic              ex_regwrite,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              halted
);

    localparam int DCW = $clog2(FLUSH_CYCLES + 1);

    logic [DW-1:0]  r_regs [NREGS];
    logic           r_ex_valid, r_ex_regwrite, r_halted;
    logic [DW-1:0]  r_ex_a, r_ex_b, r_ex_rd2, r_ex_imm8, r_ex_imm11;
    logic [RW-1:0]  r_ex_wreg;
    ctrl_t          r_ex_ctrl;
    logic [DCW-1:0] r_drop_cnt;

    ctrl_t          w_ctrl;
    logic [RW-1:0]  w_src1, w_src2, w_wreg;
    logic [DW-1:0]  w_rd1, w_rd2, w_opb, w_imm5s, w_imm5z, w_imm8s, w_imm11s;
    logic           w_stall, w_id_ready, w_id_fire;

    // An alignment fault is issued as HALT so it retires in program order.
    assign w_ctrl = if_align_err ? decode_ctrl(OP_HALT, 2'b00)
                                 : decode_ctrl(if_instr[15:11], if_instr[1:0]);

    assign w_src1   = if_instr[8 +: RW];
    assign w_src2   = if_instr[5 +: RW];
    assign w_imm5s  = {{(DW-5){if_instr[4]}}, if_instr[4:0]};
    assign w_imm5z  = {{(DW-5){1'b0}}, if_instr[4:0]};
    assign w_imm8s  = {{(DW-8){if_instr[7]}}, if_instr[7:0]};
    assign w_imm11s = {{(DW-11){if_instr[10]}}, if_instr[10:0]};

    always_comb begin
        w_wreg = RW'(NREGS - 1);
        case (w_ctrl.reg_dest)
            DEST_I:  w_wreg = if_instr[5 +: RW];
            DEST_RS: w_wreg = if_instr[8 +: RW];
            DEST_R:  w_wreg = if_instr[2 +: RW];
            default: w_wreg = RW'(NREGS - 1);
        endcase
    end

    assign w_rd1 = (wb_en && wb_reg == w_src1) ? wb_data : r_regs[w_src1];
    assign w_rd2 = (wb_en && wb_reg == w_src2) ? wb_data : r_regs[w_src2];

    always_comb begin
        w_opb = w_rd2;
        case (w_ctrl.alu_src)
            SRC_IMM5S: w_opb = w_imm5s;
            SRC_IMM5Z: w_opb = w_imm5z;
            SRC_IMM8S: w_opb = w_imm8s;
            default:   w_opb = w_rd2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (wb_en) begin
            r_regs[wb_reg] <= wb_data;
        end
    end

    decode_scoreboard #(
        .NREGS        (NREGS),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_scoreboard (
        .clk        (clk),
        .srst       (rst),
        .i_inc_en   (w_id_fire && w_ctrl.reg_write),
        .i_inc_reg  (w_wreg),
        .i_dec_en   (wb_en),
        .i_dec_reg  (wb_reg),
        .i_kill_en  (flush && r_ex_valid && r_ex_regwrite),
        .i_kill_reg (r_ex_wreg),
        .i_src1_use (w_ctrl.use_rs),
        .i_src1     (w_src1),
        .i_src2_use (w_ctrl.use_rt),
        .i_src2     (w_src2),
        .i_writes   (w_ctrl.reg_write),
        .o_stall    (w_stall)
    );

    assign w_id_ready = !rst && (!r_ex_valid || ex_ready) && !w_stall && !r_halted
                        && (r_drop_cnt == '0) && !flush;
    assign w_id_fire  = if_valid && w_id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_a        <= '0;
            r_ex_b        <= '0;
            r_ex_rd2      <= '0;
            r_ex_imm8     <= '0;
            r_ex_imm11    <= '0;
            r_ex_wreg     <= '0;
            r_ex_regwrite <= 1'b0;
            r_ex_ctrl     <= '0;
            r_halted      <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            if (flush) begin
                r_ex_valid <= 1'b0;
            end else if (w_id_fire) begin
                r_ex_valid    <= 1'b1;
                r_ex_a        <= w_rd1;
                r_ex_b        <= w_opb;
                r_ex_rd2      <= w_rd2;
                r_ex_imm8     <= w_imm8s;
                r_ex_imm11    <= w_imm11s;
                r_ex_wreg     <= w_wreg;
                r_ex_regwrite <= w_ctrl.reg_write;
                r_ex_ctrl     <= w_ctrl;
            end else if (ex_ready) begin
                r_ex_valid <= 1'b0;
            end
            if (w_id_fire && w_ctrl.halt) r_halted <= 1'b1;
            // The flush cycle itself drops one instruction; the counter covers the rest.
            if (flush)                  r_drop_cnt <= DCW'(FLUSH_CYCLES - 1);
            else if (r_drop_cnt != '0)  r_drop_cnt <= r_drop_cnt - DCW'(1);
        end
    end

    assign id_ready    = w_id_ready;
    assign ex_valid    = r_ex_valid;
    assign ex_a        = r_ex_a;
    assign ex_b        = r_ex_b;
    assign ex_rd2      = r_ex_rd2;
    assign ex_imm8     = r_ex_imm8;
    assign ex_imm11    = r_ex_imm11;
    assign ex_wreg     = r_ex_wreg;
    assign ex_regwrite = r_ex_regwrite;
    assign ex_ctrl     = r_ex_ctrl;
    assign halted      = r_halted;

endmodule
